// File: rtl/interrupt_gateway_pkg.sv
// Shared types and constants for the interrupt gateway and its arbiter.
// Port count, claim/complete id width and the per-port gateway state encoding.
package interrupt_gateway_pkg;

  localparam int NUM_INT_PORTS = 16;
  localparam int INT_ID_W      = $clog2(NUM_INT_PORTS);

  typedef logic [INT_ID_W-1:0] int_id_t;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_ACTIVE  = 2'd2
  } gw_state_e;

endpackage

// File: rtl/interrupt_gateway_cell.sv
// One gateway port: line synchroniser, rise detect, IDLE/PENDING/ACTIVE FSM
// and a single-entry repend flag that queues one edge seen while ACTIVE.
module interrupt_gateway_cell
  import interrupt_gateway_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_i,
  input  logic cfg_edge_i,
  input  logic claim_hit_i,
  input  logic complete_hit_i,
  output logic pending_o,
  output logic active_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   repend_q, repend_d;
  gw_state_e              state_q, state_d;
  logic                   sync_s, rise_s, trig_s, requeue_s;

  // Synchroniser shift and edge-detect history
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
    prev_d = sync_s;
  end

  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign rise_s    = sync_s & ~prev_q;
  assign trig_s    = cfg_edge_i ? rise_s : sync_s;
  // On completion, a queued or concurrent edge (or a still-high level) re-arms the port
  assign requeue_s = cfg_edge_i ? (repend_q | rise_s) : sync_s;

  // Port FSM next state; repend only survives in edge mode
  always_comb begin
    state_d  = state_q;
    repend_d = repend_q;
    case (state_q)
      GW_IDLE: begin
        repend_d = 1'b0;
        if (trig_s) state_d = GW_PENDING;
        else        state_d = GW_IDLE;
      end
      GW_PENDING: begin
        if (claim_hit_i) begin
          state_d  = GW_ACTIVE;
          repend_d = cfg_edge_i & rise_s;
        end else begin
          state_d  = GW_PENDING;
          repend_d = 1'b0;
        end
      end
      GW_ACTIVE: begin
        if (complete_hit_i) begin
          repend_d = 1'b0;
          if (requeue_s) state_d = GW_PENDING;
          else           state_d = GW_IDLE;
        end else begin
          state_d  = GW_ACTIVE;
          repend_d = cfg_edge_i & (repend_q | rise_s);
        end
      end
      default: begin
        state_d  = GW_IDLE;
        repend_d = 1'b0;
      end
    endcase
  end

  // State, repend and synchroniser registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      repend_q <= 1'b0;
      state_q  <= GW_IDLE;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      repend_q <= repend_d;
      state_q  <= state_d;
    end
  end

  assign pending_o = (state_q == GW_PENDING);
  assign active_o  = (state_q == GW_ACTIVE);

endmodule

// File: rtl/interrupt_gateway.sv
// Interrupt gateway: turns raw peripheral lines into the arbiter request vector,
// tracking claim/complete so each port holds at most one outstanding interrupt.
module interrupt_gateway
  import interrupt_gateway_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_INT_PORTS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] irq_src_i,
  input  logic [NUM_PORTS-1:0] cfg_edge_i,
  input  logic [NUM_PORTS-1:0] enable_i,
  output logic [NUM_PORTS-1:0] int_req_o,
  input  logic                 claim_valid_i,
  input  int_id_t              claim_id_i,
  input  logic                 complete_valid_i,
  input  int_id_t              complete_id_i,
  output logic [NUM_PORTS-1:0] pending_o,
  output logic [NUM_PORTS-1:0] active_o,
  output logic                 claim_err_o,
  output logic                 complete_err_o
);

  logic [NUM_PORTS-1:0] claim_sel_s, complete_sel_s;
  logic                 claim_err_q, claim_err_d;
  logic                 complete_err_q, complete_err_d;

  // One-hot id decode; an id with no matching port decodes to all zeros
  always_comb begin
    claim_sel_s    = '0;
    complete_sel_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      claim_sel_s[i]    = claim_valid_i & (claim_id_i == INT_ID_W'(i));
      complete_sel_s[i] = complete_valid_i & (complete_id_i == INT_ID_W'(i));
    end
  end

  // Legal only when the addressed port is in the state the handshake expects
  always_comb begin
    claim_err_d    = claim_valid_i & ~(|(claim_sel_s & pending_o));
    complete_err_d = complete_valid_i & ~(|(complete_sel_s & active_o));
  end

  // Error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      claim_err_q    <= 1'b0;
      complete_err_q <= 1'b0;
    end else begin
      claim_err_q    <= claim_err_d;
      complete_err_q <= complete_err_d;
    end
  end

  assign claim_err_o    = claim_err_q;
  assign complete_err_o = complete_err_q;
  assign int_req_o      = pending_o & enable_i;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    interrupt_gateway_cell #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cell (
      .clk            (clk),
      .rst_n          (rst_n),
      .irq_i          (irq_src_i[g]),
      .cfg_edge_i     (cfg_edge_i[g]),
      .claim_hit_i    (claim_sel_s[g]),
      .complete_hit_i (complete_sel_s[g]),
      .pending_o      (pending_o[g]),
      .active_o       (active_o[g])
    );
  end

endmodule

// File: tb/tb_interrupt_gateway.sv
// Scoreboard bench for interrupt_gateway: directed scenarios plus random traffic,
// each cycle's expected outputs come from a port-level behavioural model.
module tb_interrupt_gateway;

  localparam int NP   = 16;
  localparam int IDLE = 0;
  localparam int PEND = 1;
  localparam int ACT  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] irq_src_i, cfg_edge_i, enable_i, int_req_o, pending_o, active_o;
  logic          claim_valid_i, complete_valid_i, claim_err_o, complete_err_o;
  logic [3:0]    claim_id_i, complete_id_i;

  always #5 clk = ~clk;

  interrupt_gateway dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irq_src_i        (irq_src_i),
    .cfg_edge_i       (cfg_edge_i),
    .enable_i         (enable_i),
    .int_req_o        (int_req_o),
    .claim_valid_i    (claim_valid_i),
    .claim_id_i       (claim_id_i),
    .complete_valid_i (complete_valid_i),
    .complete_id_i    (complete_id_i),
    .pending_o        (pending_o),
    .active_o         (active_o),
    .claim_err_o      (claim_err_o),
    .complete_err_o   (complete_err_o)
  );

  typedef struct packed {
    logic [NP-1:0] req;
    logic [NP-1:0] pend;
    logic [NP-1:0] act;
    logic          cerr;
    logic          perr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: port state, queued-edge flag, and the line value seen 0..3 edges back
  int            st[NP];
  bit            rp[NP];
  logic [NP-1:0] s0, s1, s2, s3;
  logic [NP-1:0] cur_irq, cur_cfg, cur_en;

  task automatic chk(input string nm, input logic [NP-1:0] act, input logic [NP-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      st[i] = IDLE;
      rp[i] = 1'b0;
    end
    s0 = '0; s1 = '0; s2 = '0; s3 = '0;
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after the next edge
  task automatic step(input bit cv, input int cid, input bit pv, input int pid);
    int   old_st[NP];
    exp_t e;
    @(negedge clk);
    irq_src_i        = cur_irq;
    cfg_edge_i       = cur_cfg;
    enable_i         = cur_en;
    claim_valid_i    = cv;
    claim_id_i       = 4'(cid);
    complete_valid_i = pv;
    complete_id_i    = 4'(pid);
    s3 = s2; s2 = s1; s1 = s0; s0 = cur_irq;
    old_st = st;
    for (int i = 0; i < NP; i++) begin
      bit lvl, rise, edg, trig, cm, pm;
      lvl  = s2[i];
      rise = s2[i] & ~s3[i];
      edg  = cur_cfg[i];
      trig = edg ? rise : lvl;
      cm   = cv && (cid == i);
      pm   = pv && (pid == i);
      if (old_st[i] == IDLE) begin
        if (trig) st[i] = PEND;
      end else if (old_st[i] == PEND) begin
        if (cm) begin
          st[i] = ACT;
          rp[i] = edg && rise;
        end
      end else begin
        if (pm) begin
          st[i] = (edg ? (rp[i] || rise) : lvl) ? PEND : IDLE;
          rp[i] = 1'b0;
        end else if (edg && rise) begin
          rp[i] = 1'b1;
        end
      end
      if (!edg) rp[i] = 1'b0;
    end
    e.cerr = cv && ((cid >= NP) ? 1'b1 : (old_st[cid] != PEND));
    e.perr = pv && ((pid >= NP) ? 1'b1 : (old_st[pid] != ACT));
    for (int i = 0; i < NP; i++) begin
      e.pend[i] = (st[i] == PEND);
      e.act[i]  = (st[i] == ACT);
    end
    e.req = e.pend & cur_en;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic pulse(input int p);
    cur_irq[p] = 1'b1;
    step(1'b0, 0, 1'b0, 0);
    cur_irq[p] = 1'b0;
  endtask

  // Monitor: after every active edge compare the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("int_req", int_req_o, e.req);
        chk("pending", pending_o, e.pend);
        chk("active", active_o, e.act);
        chk("claim_err", {15'd0, claim_err_o}, {15'd0, e.cerr});
        chk("complete_err", {15'd0, complete_err_o}, {15'd0, e.perr});
      end
    end
  end

  initial begin
    int pl[$];
    int al[$];
    bit cv, pv;
    int cid, pid;

    rst_n = 1'b0;
    cur_irq = '0; cur_cfg = 16'hFFFE; cur_en = 16'hFF7F;
    irq_src_i = '0; cfg_edge_i = cur_cfg; enable_i = cur_en;
    claim_valid_i = 1'b0; claim_id_i = 4'd0;
    complete_valid_i = 1'b0; complete_id_i = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", int_req_o, 16'h0000);
    chk("reset_pend", pending_o, 16'h0000);
    chk("reset_act", active_o, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Edge capture, claim and complete on port 3
    pulse(3); idle(3);
    step(1'b1, 3, 1'b0, 0); idle(1);
    step(1'b0, 0, 1'b1, 3); idle(1);

    // Two edges while ACTIVE queue only one re-pend on port 5
    pulse(5); idle(3);
    step(1'b1, 5, 1'b0, 0);
    pulse(5); idle(1); pulse(5); idle(3);
    step(1'b0, 0, 1'b1, 5); idle(1);
    step(1'b1, 5, 1'b0, 0); idle(1);
    step(1'b0, 0, 1'b1, 5); idle(3);

    // Level mode on port 0
    cur_irq[0] = 1'b1; idle(3);
    step(1'b1, 0, 1'b0, 0); idle(1);
    step(1'b0, 0, 1'b1, 0); idle(1);
    cur_irq[0] = 1'b0; idle(3);
    step(1'b1, 0, 1'b0, 0);
    step(1'b0, 0, 1'b1, 0); idle(2);

    // Masked capture on port 7, request appears as soon as the mask opens
    pulse(7); idle(3);
    cur_en[7] = 1'b1;
    step(1'b0, 0, 1'b0, 0);
    #1;
    chk("mask_open_req7", int_req_o & 16'h0080, 16'h0080);
    step(1'b1, 7, 1'b0, 0);
    step(1'b0, 0, 1'b1, 7); idle(1);

    // Illegal handshakes
    step(1'b1, 9, 1'b0, 0); idle(1);
    pulse(2); idle(3);
    step(1'b0, 0, 1'b1, 2); idle(1);
    step(1'b1, 2, 1'b0, 0);
    step(1'b1, 2, 1'b1, 2); idle(2);

    // Asynchronous reset with ports 1 and 4 ACTIVE
    cur_irq[1] = 1'b1; cur_irq[4] = 1'b1;
    step(1'b0, 0, 1'b0, 0);
    cur_irq[1] = 1'b0; cur_irq[4] = 1'b0;
    idle(3);
    step(1'b1, 1, 1'b0, 0);
    step(1'b1, 4, 1'b0, 0); idle(1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", int_req_o, 16'h0000);
    chk("async_rst_pend", pending_o, 16'h0000);
    chk("async_rst_act", active_o, 16'h0000);
    chk("async_rst_err", {14'd0, claim_err_o, complete_err_o}, 16'h0000);
    model_reset();
    cur_irq = '0;
    @(negedge clk);
    irq_src_i = '0; claim_valid_i = 1'b0; complete_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Random traffic
    cur_en = 16'hFFFF;
    for (int c = 0; c < 400; c++) begin
      cur_irq = cur_irq ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) cur_cfg = 16'($urandom);
      if ($urandom_range(0, 7) == 0)  cur_en  = 16'($urandom | $urandom);
      pl.delete(); al.delete();
      for (int i = 0; i < NP; i++) begin
        if (st[i] == PEND) pl.push_back(i);
        if (st[i] == ACT)  al.push_back(i);
      end
      cv  = ($urandom_range(0, 2) == 0);
      pv  = ($urandom_range(0, 2) == 0);
      cid = (pl.size() > 0 && $urandom_range(0, 3) != 0) ?
            pl[$urandom_range(0, pl.size() - 1)] : $urandom_range(0, NP - 1);
      pid = (al.size() > 0 && $urandom_range(0, 3) != 0) ?
            al[$urandom_range(0, al.size() - 1)] : $urandom_range(0, NP - 1);
      step(cv, cid, pv, pid);
    end
    idle(2);

    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/interrupt_gateway.md
Name: interrupt_gateway

Overview:
- Source-side counterpart of the interrupt arbiter. Captures raw per-port interrupt lines and produces the request vector the arbiter consumes.
- Consumes the arbiter/CPU claim and complete handshakes, so each port carries at most one outstanding interrupt at a time.
- Sits between the peripheral interrupt lines and the interrupt arbiter, one instance per arbiter.

Parameters:
- NUM_PORTS, default InterruptArbiterPkg::NUM_INT_PORTS (16), number of interrupt ports.
- SYNC_STAGES, default 2, synchroniser depth on irq_src_i (legal range 2..3).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- irq_src_i  input  NUM_PORTS  raw interrupt lines, asynchronous to clk.
- cfg_edge_i  input  NUM_PORTS  per port: 1 = rising-edge triggered, 0 = level (high) triggered; quasi-static.
- enable_i  input  NUM_PORTS  per-port request mask.
- int_req_o  output  NUM_PORTS  request vector to the arbiter.
- claim_valid_i  input  1  arbiter/CPU claims port claim_id_i this cycle.
- claim_id_i  input  INT_ID_W  claimed port index.
- complete_valid_i  input  1  handler signals completion of port complete_id_i.
- complete_id_i  input  INT_ID_W  completed port index.
- pending_o  output  NUM_PORTS  status: port in PENDING.
- active_o  output  NUM_PORTS  status: port in ACTIVE.
- claim_err_o  output  1  one-cycle pulse: illegal claim.
- complete_err_o  output  1  one-cycle pulse: illegal complete.

Behaviour:
- Reset (rst_n low, asynchronous): all sync and edge-detect flops, all port states (IDLE) and the repend bits are cleared. All outputs read 0 while reset is held. Deassertion is used as-is; no internal reset synchroniser.
- Synchroniser: irq_src_i passes SYNC_STAGES flops. The edge detector compares the synchronised value with its one-cycle-delayed copy; rise = sync & ~prev.
- Trigger event per port:
  - Edge mode: the trigger is rise.
  - Level mode: the trigger is the synchronised level being high.
- Per-port FSM {IDLE, PENDING, ACTIVE}:
  - IDLE -> PENDING on trigger.
  - PENDING -> ACTIVE on a claim whose claim_id_i matches the port.
  - ACTIVE -> IDLE on a complete whose complete_id_i matches the port, when repend = 0 and no level trigger is present.
  - ACTIVE -> PENDING on that same complete when repend = 1 (edge mode), or when the level is still high (level mode). repend is cleared on that transition.
  - Edge mode only: a rise seen while in PENDING is absorbed; a rise seen while in ACTIVE sets repend (at most one queued interrupt).
- Outputs:
  - int_req_o[i] = (state == PENDING) & enable_i[i]. This is a decode of registered state, with no combinational path from claim or complete.
  - pending_o and active_o are decodes of the state register.
  - The mask does not block capture: a disabled port still goes to PENDING and raises int_req_o the cycle enable_i rises.
- Latency: for an edge on irq_src_i meeting setup before clock edge k, with SYNC_STAGES = 2, int_req_o goes high after edge k+2. A claim at edge m drops int_req_o after edge m.
- Illegal claim: claim_valid_i to a port not in PENDING, or claim_id_i >= NUM_PORTS. The state is unchanged and claim_err_o is high for the next cycle.
- Illegal complete: complete to a port not in ACTIVE, or an out-of-range id. The state is unchanged and complete_err_o pulses.
- Simultaneous events:
  - Claim and complete in the same cycle to different ports: both take effect.
  - Claim and complete to the same ACTIVE port: the complete takes effect and the claim is flagged illegal.
  - A trigger in the same cycle as a claim of that port: the claim wins and, in edge mode, repend is set.
- cfg_edge_i change while a port is not IDLE: the new mode applies from the next evaluation; repend is cleared when the port is in level mode.

Decomposition:
- InterruptArbiterPkg gains:
  - INT_ID_W = $clog2(NUM_INT_PORTS);
  - typedef logic [INT_ID_W-1:0] int_id_t;
  - typedef enum logic [1:0] {GW_IDLE, GW_PENDING, GW_ACTIVE} gw_state_e.
- Sub-module interrupt_gateway_cell (one per port) holds the synchroniser, edge detect, FSM and repend bit. Inputs: per-port claim_hit and complete_hit. Outputs: state decodes.
- The top level does id decode, the error pulses and the generate loop.

Test Plan:
- Edge capture: port 3 edge mode, enable set, single irq_src_i[3] pulse -> int_req_o = 16'h0008 after 3 edges. Claim id 3 -> active_o[3] = 1, int_req_o = 0. Complete id 3 -> all state IDLE.
- Repend: port 5 edge mode; claim it, pulse irq_src_i[5] twice while ACTIVE, then complete -> port 5 returns to PENDING once. A second claim/complete -> IDLE (only one queued).
- Level mode: port 0 level mode, line held high across claim/complete -> back to PENDING after complete. Drop the line, then claim/complete -> IDLE.
- Mask: port 7 captures with enable_i[7] = 0 -> pending_o[7] = 1, int_req_o[7] = 0. Raise enable -> int_req_o[7] = 1 the same cycle.
- Errors: claim id 9 while IDLE -> claim_err_o pulses 1 cycle, no state change. Complete id 2 while PENDING -> complete_err_o pulses. Claim and complete to the same ACTIVE port -> IDLE plus claim_err_o.
- Reset mid-operation: ports 1 and 4 ACTIVE, drop rst_n asynchronously between edges -> all outputs 0 immediately. After release with lines low, no requests appear.
